// File: rtl/rr_arb4_enc.sv
// Four-way round-robin arbiter with an encoded (a,b) grant code, a hold-until-done
// grant phase and an optional grant-hold timeout that forces release.
module rr_arb4_enc #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic       a,
    output logic       b,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    // Count value on the last GRANT cycle a timeout allows.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [1:0]       code_nxt;
    logic             gnt_valid_nxt;
    logic             timeout_nxt;

    // First set request in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] off;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            off = 2'(k);
            idx = p + off;
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            count     <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            count     <= count_nxt;
            a         <= code_nxt[1];
            b         <= code_nxt[0];
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        count_nxt     = count;
        code_nxt      = {a, b};
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                gnt_valid_nxt = 1'b0;
                if (|req) begin
                    code_nxt      = rr_pick(req, ptr);
                    gnt_valid_nxt = 1'b1;
                    count_nxt     = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                // done takes precedence over a coincident timeout
                if (done || (TIMEOUT != 0 && count == TO_LAST)) begin
                    state_nxt     = IDLE;
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = {a, b};
                    count_nxt     = '0;
                    timeout_nxt   = !done;
                end else if (count != '1) begin
                    count_nxt = count + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Directed bench for rr_arb4_enc: one instance with the default timeout and one
// with TIMEOUT=4, outputs checked one time unit after each rising edge.
module tb_rr_arb4_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req0, req1;
    logic       done0, done1;
    logic       a0, b0, gv0, to0;
    logic       a1, b1, gv1, to1;
    logic [3:0] o0, o1;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    assign o0 = {a0, b0, gv0, to0};
    assign o1 = {a1, b1, gv1, to1};

    rr_arb4_enc #(.CNT_W(4), .TIMEOUT(15)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .done(done0),
        .a(a0), .b(b0), .gnt_valid(gv0), .timeout(to0)
    );

    rr_arb4_enc #(.CNT_W(4), .TIMEOUT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .done(done1),
        .a(a1), .b(b1), .gnt_valid(gv1), .timeout(to1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = '0; done0 = 1'b0; req1 = '0; done1 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req0 = '0; done0 = 1'b0; req1 = '0; done1 = 1'b0;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (o0 !== 4'b0000) begin n_bad++; $display("FAIL reset_dut0: got {a,b,gv,to}=%b want 0000", o0); end
        n_cmp++;
        if (o1 !== 4'b0000) begin n_bad++; $display("FAIL reset_dut1: got {a,b,gv,to}=%b want 0000", o1); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req0 = 4'b0100;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_cmp++;
            if (o0 !== 4'b1010) begin n_bad++; $display("FAIL single_grant_c%0d: got %b want 1010", c, o0); end
        end
        done0 = 1'b1; req0 = '0;
        tick();
        done0 = 1'b0;
        n_cmp++;
        if (o0 !== 4'b1000) begin n_bad++; $display("FAIL single_release: got %b want 1000", o0); end
        tick();
        n_cmp++;
        if (o0 !== 4'b1000) begin n_bad++; $display("FAIL single_hold_code: got %b want 1000", o0); end
    endtask

    task automatic test_fairness();
        logic [1:0] code;
        do_reset();
        req0 = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            code = 2'(g);
            tick();
            n_cmp++;
            if (o0 !== {code, 2'b10}) begin n_bad++; $display("FAIL fair_g%0d_c1: got %b want %b", g, o0, {code, 2'b10}); end
            tick();
            n_cmp++;
            if (o0 !== {code, 2'b10}) begin n_bad++; $display("FAIL fair_g%0d_c2: got %b want %b", g, o0, {code, 2'b10}); end
            done0 = 1'b1;
            if (g == 4) req0 = '0;
            tick();
            done0 = 1'b0;
            n_cmp++;
            if (o0 !== {code, 2'b00}) begin n_bad++; $display("FAIL fair_g%0d_gap: got %b want %b", g, o0, {code, 2'b00}); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req1 = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++;
            if (o1 !== 4'b0110) begin n_bad++; $display("FAIL to_grant_c%0d: got %b want 0110", c, o1); end
        end
        tick();
        n_cmp++;
        if (o1 !== 4'b0101) begin n_bad++; $display("FAIL to_pulse: got %b want 0101", o1); end
        req1 = 4'b0111;
        tick();
        n_cmp++;
        if (o1 !== 4'b1010) begin n_bad++; $display("FAIL to_next_grant: got %b want 1010", o1); end
        done1 = 1'b1; req1 = '0;
        tick();
        done1 = 1'b0;
        n_cmp++;
        if (o1 !== 4'b1000) begin n_bad++; $display("FAIL to_cleanup: got %b want 1000", o1); end
    endtask

    task automatic test_collision();
        do_reset();
        req1 = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            tick();
            n_cmp++;
            if (o1 !== 4'b0010) begin n_bad++; $display("FAIL coll_grant_c%0d: got %b want 0010", c, o1); end
            if (c == 1) req1 = '0;
            if (c == 4) done1 = 1'b1;
        end
        tick();
        done1 = 1'b0;
        n_cmp++;
        if (o1 !== 4'b0000) begin n_bad++; $display("FAIL coll_release: got %b want 0000", o1); end
        tick();
        n_cmp++;
        if (o1 !== 4'b0000) begin n_bad++; $display("FAIL coll_after: got %b want 0000", o1); end
    endtask

    task automatic test_drop();
        do_reset();
        req0 = 4'b1000;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if (o0 !== 4'b1110) begin n_bad++; $display("FAIL drop_c%0d: got %b want 1110", c, o0); end
            if (c == 1) req0 = '0;
            if (c == 5) done0 = 1'b1;
        end
        tick();
        done0 = 1'b0;
        n_cmp++;
        if (o0 !== 4'b1100) begin n_bad++; $display("FAIL drop_release: got %b want 1100", o0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0 = 4'b0100;
        tick();
        n_cmp++;
        if (o0 !== 4'b1010) begin n_bad++; $display("FAIL mid_pre: got %b want 1010", o0); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o0 !== 4'b0000) begin n_bad++; $display("FAIL mid_async: got %b want 0000", o0); end
        req0 = '0;
        tick();
        n_cmp++;
        if (o0 !== 4'b0000) begin n_bad++; $display("FAIL mid_held: got %b want 0000", o0); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_collision();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arb4_enc.md
RR_ARB4_ENC -- requirements
Module: rr_arb4_enc

Interface
REQ-001 The block SHALL be parameterised as follows, one parameter per line:
- CNT_W, 4, width of the grant-hold timeout counter.
- TIMEOUT, 15, maximum GRANT cycles without done; 0 disables timeout; legal range 0..2^CNT_W-1.
REQ-002 The block SHALL have exactly the following ports, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] is requester i.
- done  input  1  granted requester finished; sampled only in GRANT.
- a  output  1  registered grant code MSB, drives the downstream 2-to-4 decoder.
- b  output  1  registered grant code LSB.
- gnt_valid  output  1  registered; high while a,b carry a live grant.
- timeout  output  1  registered one-cycle pulse on forced release.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL implement two states: IDLE and GRANT.
REQ-005 In IDLE with req!=0, the block SHALL select the first set req bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
- It SHALL load {a,b} with that index.
- It SHALL set gnt_valid=1 and enter GRANT on the next edge.
REQ-006 In IDLE with req==0, the block SHALL stay in IDLE with gnt_valid=0 and a,b unchanged.
REQ-007 Latency SHALL be one cycle: req sampled high in IDLE at edge n gives gnt_valid=1 after edge n.
REQ-008 In GRANT, the block SHALL hold {a,b} and gnt_valid=1 constant regardless of req, including when the granted req bit drops.
REQ-009 The hold counter SHALL be 0 on the first GRANT cycle and SHALL increment by 1 on each subsequent GRANT cycle.
REQ-010 On done=1 in GRANT, the block SHALL do the following on the next edge:
- set gnt_valid=0;
- set ptr to the granted index;
- return to IDLE.
REQ-011 If TIMEOUT!=0, done=0 and count==TIMEOUT-1 in GRANT, the block SHALL do the following on the next edge:
- release exactly as REQ-010;
- set timeout=1 for exactly one cycle.
gnt_valid is therefore high for exactly TIMEOUT cycles in this case.
REQ-012 When done=1 coincides with the final timeout cycle, done SHALL win and timeout SHALL stay 0.
REQ-013 After any release, gnt_valid SHALL be 0 for at least one cycle (the IDLE arbitration cycle) before the next grant.
REQ-014 While gnt_valid=0, a,b SHALL hold the last granted code.
REQ-015 The counter SHALL NOT wrap. When TIMEOUT==0 it SHALL saturate at 2^CNT_W-1 and GRANT SHALL persist until done.
REQ-016 ptr SHALL be 2 bits and SHALL wrap 3->0 in the priority search.

Reset
REQ-017 While rst_n=0 the block SHALL hold these values, independent of clk:
- a=0, b=0, gnt_valid=0, timeout=0;
- count=0, ptr=3, state=IDLE.
REQ-018 Reset asserted mid-GRANT SHALL abort the grant immediately, with no timeout pulse.
REQ-019 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with rst_n=1.
REQ-020 With ptr=3 after reset, the first grant SHALL use priority order 0,1,2,3.

Verification
REQ-021 Reset: assert rst_n=0 during GRANT with {a,b}=2'b10 -> a=b=gnt_valid=timeout=0 immediately, without a clock edge.
REQ-022 Single request: req=4'b0100, pulse done on the 3rd GRANT cycle.
- gnt_valid=1 one cycle after req, with a=1, b=0.
- gnt_valid high 3 cycles, then 0; a,b stay 1,0.
REQ-023 Fairness: req=4'b1111 held, done on each 2nd GRANT cycle.
- grant codes SHALL be 00,01,10,11,00.
- each grant lasts 2 cycles, separated by exactly 1 gnt_valid=0 cycle.
REQ-024 Timeout: TIMEOUT=4, req=4'b0010, done=0.
- gnt_valid high exactly 4 cycles with {a,b}=01.
- then timeout=1 for 1 cycle with gnt_valid=0.
- the next grant goes to the next requester after 1.
REQ-025 Collision: TIMEOUT=4, done=1 on the 4th GRANT cycle -> release with timeout=0 throughout.
REQ-026 Drop: req=4'b1000, clear req on GRANT cycle 1, done on cycle 5 -> gnt_valid stays 1 and {a,b}=11 for all 5 cycles.
